// File: rtl/branch_predict_ctrl.sv
// Decode-stage 2-bit BHT branch predictor with Execute-stage mispredict recovery.
// Drives the fetch PC select and the Decode/Execute squash requests, and counts branches and redirects.
module branch_predict_ctrl #(
    parameter int BHT_ENTRIES = 64,
    parameter int PC_W        = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc_d,
    input  logic            branch_d,
    input  logic [PC_W-1:0] target_d,
    input  logic            stall_d,
    input  logic            flush_e,
    input  logic            branch_e,
    input  logic            jump_e,
    input  logic            pc_src_e,
    input  logic [PC_W-1:0] pc_target_e,
    input  logic [PC_W-1:0] pc_plus4_e,
    output logic [1:0]      next_pc_sel,
    output logic [PC_W-1:0] recover_pc,
    output logic            flush_d_req,
    output logic            flush_e_req,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] idx_e;
    logic             pred_d;
    logic             pred_e;
    logic             valid_e;
    logic             mis_e;
    logic             bht_upd;

    // target_d is muxed by the fetch stage; only the index bits of pc_d matter here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_d[1:0], pc_d[PC_W-1:IDX_W+2], target_d};

    assign idx_d   = pc_d[IDX_W+1:2];
    assign pred_d  = branch_d & bht[idx_d][1];
    assign mis_e   = valid_e & ((branch_e & (pred_e != pc_src_e)) | (jump_e & pc_src_e));
    assign bht_upd = valid_e & branch_e;

    // Execute mispredict outranks the Decode prediction; a stalled Decode never redirects.
    always_comb begin
        next_pc_sel = 2'b00;
        recover_pc  = '0;
        flush_d_req = 1'b0;
        flush_e_req = 1'b0;
        if (mis_e) begin
            next_pc_sel = 2'b10;
            recover_pc  = pc_src_e ? pc_target_e : pc_plus4_e;
            flush_d_req = 1'b1;
            flush_e_req = 1'b1;
        end else if (pred_d && !stall_d) begin
            next_pc_sel = 2'b01;
            flush_d_req = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_e <= 1'b0;
            pred_e  <= 1'b0;
            idx_e   <= '0;
        end else if (flush_e || flush_e_req) begin
            valid_e <= 1'b0;
            pred_e  <= 1'b0;
        end else if (!stall_d) begin
            valid_e <= 1'b1;
            pred_e  <= pred_d;
            idx_e   <= idx_d;
        end
    end

    // Reads in Decode see the pre-update counter; there is deliberately no write bypass.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (bht_upd) begin
            if (pc_src_e) begin
                if (bht[idx_e] != 2'b11) begin
                    bht[idx_e] <= bht[idx_e] + 2'b01;
                end
            end else if (bht[idx_e] != 2'b00) begin
                bht[idx_e] <= bht[idx_e] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (bht_upd) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mis_e) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule
